// File: rtl/laser500_mem_arbiter.sv
// Single-owner SDRAM access scheduler for the Laser500: data_io download, VTL video fetch, Z80 CPU.
// Latency: grant in ARB at cycle 0, ISSUE at 1, ack at 2+RD_LAT; each completion is followed by one idle ARB cycle.
// Backpressure: requests are held levels; the requester waits for its one-cycle ack, the Z80 via cpu_wait_n.
// Optional feature macro: LASER500_CPU_FAIRNESS_EN (bounded video streak while the CPU waits).
module laser500_mem_arbiter #(
    parameter int ADDR_W         = 25,
    parameter int RD_LAT         = 1,
    parameter int MAX_VID_STREAK = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dio_req,
    input  logic [ADDR_W-1:0] dio_addr,
    input  logic [7:0]        dio_data,
    output logic              dio_ack,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [7:0]        vid_data,
    output logic              vid_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_ack,
    output logic              cpu_wait_n,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [7:0]        sd_din,
    output logic              sd_we,
    output logic              sd_oe,
    input  logic [7:0]        sd_dout
);

    // The latency counter is 3 bits wide and the streak counter saturates in 3 bits.
    if (RD_LAT < 1 || RD_LAT > 7 || MAX_VID_STREAK < 1 || MAX_VID_STREAK > 7) begin : g_bad_param
        $error("laser500_mem_arbiter: RD_LAT and MAX_VID_STREAK must be in 1..7");
    end

    typedef enum logic [1:0] {ST_ARB, ST_ISSUE, ST_WAIT} state_t;
    typedef enum logic [1:0] {G_NONE, G_DIO, G_VID, G_CPU} grant_t;

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

    state_t              r_state;
    state_t              w_next;
    grant_t              r_grant;
    grant_t              w_sel;
    logic                w_done;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_din;
    logic                r_we;
    logic [2:0]          r_lat_cnt;
    logic                r_dio_ack;
    logic                r_vid_ack;
    logic                r_cpu_ack;
    logic [7:0]          r_vid_data;
    logic [7:0]          r_cpu_dout;
    logic                w_turnaround;
    logic                w_dio_rq;
    logic                w_vid_rq;
    logic                w_cpu_rq;
    logic                w_cpu_first;

    // The just-acked requester still shows its old req level during the ack cycle, so it is masked.
    assign w_dio_rq     = dio_req && !r_dio_ack;
    assign w_vid_rq     = vid_req && !r_vid_ack;
    assign w_cpu_rq     = cpu_req && !r_cpu_ack;
    // The ack cycle is a turnaround: nobody is granted, giving requesters time to drop or renew req.
    assign w_turnaround = r_dio_ack || r_vid_ack || r_cpu_ack;

`ifdef LASER500_CPU_FAIRNESS_EN
    localparam logic [2:0] STREAK_MAX = 3'(MAX_VID_STREAK);
    logic [2:0] r_streak;

    // Count video grants that overtook a waiting CPU; clear once the CPU is served or stops asking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_streak <= 3'd0;
        end else if (r_state == ST_ARB) begin
            if (!cpu_req || w_sel == G_CPU) begin
                r_streak <= 3'd0;
            end else if (w_sel == G_VID && w_cpu_rq) begin
                r_streak <= r_streak + 3'd1;
            end
        end
    end

    assign w_cpu_first = w_cpu_rq && (r_streak >= STREAK_MAX);
`else
    assign w_cpu_first = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, grant selection and completion detect.
    always_comb begin
        w_next = r_state;
        w_sel  = G_NONE;
        w_done = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (!w_turnaround) begin
                    if (w_dio_rq)         w_sel = G_DIO;
                    else if (w_cpu_first) w_sel = G_CPU;
                    else if (w_vid_rq)    w_sel = G_VID;
                    else if (w_cpu_rq)    w_sel = G_CPU;
                end
                if (w_sel != G_NONE) w_next = ST_ISSUE;
            end
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT: begin
                if (r_lat_cnt == 3'd0) begin
                    w_done = 1'b1;
                    w_next = ST_ARB;
                end
            end
            default: w_next = ST_ARB;
        endcase
    end

    // Latch the winner's access, run the read latency counter, capture read data and pulse the ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant    <= G_NONE;
            r_addr     <= '0;
            r_din      <= 8'd0;
            r_we       <= 1'b0;
            r_lat_cnt  <= 3'd0;
            r_dio_ack  <= 1'b0;
            r_vid_ack  <= 1'b0;
            r_cpu_ack  <= 1'b0;
            r_vid_data <= 8'd0;
            r_cpu_dout <= 8'd0;
        end else begin
            r_dio_ack <= 1'b0;
            r_vid_ack <= 1'b0;
            r_cpu_ack <= 1'b0;

            if (r_state == ST_ARB) begin
                r_grant <= w_sel;
                case (w_sel)
                    G_DIO: begin
                        r_addr <= dio_addr;
                        r_din  <= dio_data;
                        r_we   <= 1'b1;
                    end
                    G_VID: begin
                        r_addr <= vid_addr;
                        r_we   <= 1'b0;
                    end
                    G_CPU: begin
                        r_addr <= cpu_addr;
                        r_we   <= cpu_we;
                        if (cpu_we) r_din <= cpu_din;
                    end
                    default: ;
                endcase
            end

            if (r_state == ST_ISSUE) begin
                r_lat_cnt <= LAT_INIT;
            end else if (r_state == ST_WAIT && r_lat_cnt != 3'd0) begin
                r_lat_cnt <= r_lat_cnt - 3'd1;
            end

            if (w_done) begin
                case (r_grant)
                    G_DIO: r_dio_ack <= 1'b1;
                    G_VID: begin
                        r_vid_ack  <= 1'b1;
                        r_vid_data <= sd_dout;
                    end
                    G_CPU: begin
                        r_cpu_ack <= 1'b1;
                        if (!r_we) r_cpu_dout <= sd_dout;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sd_addr    = r_addr;
    assign sd_din     = r_din;
    assign sd_we      = (r_state == ST_ISSUE) && r_we;
    assign sd_oe      = (r_state == ST_ISSUE) && !r_we;
    assign dio_ack    = r_dio_ack;
    assign vid_ack    = r_vid_ack;
    assign cpu_ack    = r_cpu_ack;
    assign vid_data   = r_vid_data;
    assign cpu_dout   = r_cpu_dout;
    assign cpu_wait_n = !(cpu_req && !r_cpu_ack);

endmodule

// File: tb/tb_laser500_mem_arbiter.sv
// Directed bench for laser500_mem_arbiter: one instance at RD_LAT=1, one at RD_LAT=3, sharing all inputs.
// Cycle k of a test means k rising edges after the request was raised; outputs sampled 1 time unit after the edge.
// Every expectation below is a hand-computed constant.
module tb_laser500_mem_arbiter;

    localparam int AW = 25;

    logic          clk = 1'b0;
    logic          reset;
    logic          dio_req, vid_req, cpu_req, cpu_we;
    logic [AW-1:0] dio_addr, vid_addr, cpu_addr;
    logic [7:0]    dio_data, cpu_din, sd_dout;

    logic          dio_ack, vid_ack, cpu_ack, cpu_wait_n, sd_we, sd_oe;
    logic [7:0]    vid_data, cpu_dout, sd_din;
    logic [AW-1:0] sd_addr;

    logic          dio_ack3, vid_ack3, cpu_ack3, cpu_wait_n3, sd_we3, sd_oe3;
    logic [7:0]    vid_data3, cpu_dout3, sd_din3;
    logic [AW-1:0] sd_addr3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    laser500_mem_arbiter #(.ADDR_W(AW), .RD_LAT(1), .MAX_VID_STREAK(3)) dut (
        .clk(clk), .reset(reset),
        .dio_req(dio_req), .dio_addr(dio_addr), .dio_data(dio_data), .dio_ack(dio_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_ack(vid_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_wait_n(cpu_wait_n),
        .sd_addr(sd_addr), .sd_din(sd_din), .sd_we(sd_we), .sd_oe(sd_oe), .sd_dout(sd_dout)
    );

    laser500_mem_arbiter #(.ADDR_W(AW), .RD_LAT(3), .MAX_VID_STREAK(3)) dut3 (
        .clk(clk), .reset(reset),
        .dio_req(dio_req), .dio_addr(dio_addr), .dio_data(dio_data), .dio_ack(dio_ack3),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data3), .vid_ack(vid_ack3),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout3), .cpu_ack(cpu_ack3), .cpu_wait_n(cpu_wait_n3),
        .sd_addr(sd_addr3), .sd_din(sd_din3), .sd_we(sd_we3), .sd_oe(sd_oe3), .sd_dout(sd_dout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int cyc_dio, cyc_vid, cyc_cpu, n_vid, n_cpu, vid_before_cpu;

    initial begin
        reset = 1'b1;
        dio_req = 0; vid_req = 0; cpu_req = 0; cpu_we = 0;
        dio_addr = '0; vid_addr = '0; cpu_addr = '0;
        dio_data = 8'h00; cpu_din = 8'h00; sd_dout = 8'h00;
        do_reset();

        // Reset state on both instances
        check("rst_dio_ack", dio_ack, 0);
        check("rst_vid_ack", vid_ack, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_sd_we", sd_we, 0);
        check("rst_sd_oe", sd_oe, 0);
        check("rst_sd_addr", sd_addr, 0);
        check("rst_sd_din", sd_din, 0);
        check("rst_vid_data", vid_data, 0);
        check("rst_cpu_dout", cpu_dout, 0);
        check("rst_wait_n", cpu_wait_n, 1);
        check("rst3_sd_oe", sd_oe3, 0);
        check("rst3_sd_we", sd_we3, 0);
        check("rst3_wait_n", cpu_wait_n3, 1);
        check("rst3_acks", {dio_ack3, vid_ack3, cpu_ack3}, 0);
        check("rst3_bus", {sd_addr3, sd_din3}, 0);
        check("rst3_data", {vid_data3, cpu_dout3}, 0);

        // 1. CPU read, RD_LAT=1
        tick();
        cpu_req = 1; cpu_we = 0; cpu_addr = 25'h04000; sd_dout = 8'h5A;
        #1;
        check("t1_wait_n_c0", cpu_wait_n, 0);
        check("t1_oe_c0", sd_oe, 0);
        tick();
        check("t1_oe_c1", sd_oe, 1);
        check("t1_addr_c1", sd_addr, 25'h04000);
        check("t1_wait_n_c1", cpu_wait_n, 0);
        tick();
        check("t1_oe_c2", sd_oe, 0);
        check("t1_ack_c2", cpu_ack, 0);
        check("t1_wait_n_c2", cpu_wait_n, 0);
        tick();
        check("t1_ack_c3", cpu_ack, 1);
        check("t1_dout", cpu_dout, 8'h5A);
        check("t1_wait_n_c3", cpu_wait_n, 1);
        cpu_req = 0;
        tick();
        check("t1_ack_c4", cpu_ack, 0);

        // 2. CPU write 0xC3 to 0x08001
        cpu_req = 1; cpu_we = 1; cpu_addr = 25'h08001; cpu_din = 8'hC3; sd_dout = 8'hEE;
        tick();
        check("t2_we_c1", sd_we, 1);
        check("t2_oe_c1", sd_oe, 0);
        check("t2_addr_c1", sd_addr, 25'h08001);
        check("t2_din_c1", sd_din, 8'hC3);
        tick();
        check("t2_we_c2", sd_we, 0);
        tick();
        check("t2_ack_c3", cpu_ack, 1);
        check("t2_dout_kept", cpu_dout, 8'h5A);
        check("t2_addr_hold", sd_addr, 25'h08001);
        cpu_req = 0; cpu_we = 0;
        tick();

        // 3. All three raised together: grants dio, vid, cpu; acks at 3, 7, 11
        dio_req = 1; dio_addr = 25'h00100; dio_data = 8'h3C;
        vid_req = 1; vid_addr = 25'h00200;
        cpu_req = 1; cpu_we = 0; cpu_addr = 25'h00300;
        sd_dout = 8'h77;
        cyc_dio = -1; cyc_vid = -1; cyc_cpu = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) begin
                check("t3_dio_we", sd_we, 1);
                check("t3_dio_addr", sd_addr, 25'h00100);
                check("t3_dio_din", sd_din, 8'h3C);
            end
            if (dio_ack) begin cyc_dio = c; dio_req = 0; end
            if (vid_ack) begin cyc_vid = c; vid_req = 0; end
            if (cpu_ack) begin cyc_cpu = c; cpu_req = 0; end
        end
        check("t3_dio_cycle", cyc_dio, 3);
        check("t3_vid_cycle", cyc_vid, 7);
        check("t3_cpu_cycle", cyc_cpu, 11);
        check("t3_vid_data", vid_data, 8'h77);
        check("t3_cpu_dout", cpu_dout, 8'h77);
        dio_req = 0; vid_req = 0; cpu_req = 0;
        do_reset();
        tick();

        // 4. Video held continuously alongside a CPU read, 40 cycles
        vid_req = 1; vid_addr = 25'h00400;
        cpu_req = 1; cpu_we = 0; cpu_addr = 25'h00500;
        n_vid = 0; n_cpu = 0; vid_before_cpu = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (vid_ack) n_vid++;
            if (cpu_ack) begin
                if (n_cpu == 0) vid_before_cpu = n_vid;
                n_cpu++;
                cpu_req = 0;
            end
        end
`ifdef LASER500_CPU_FAIRNESS_EN
        check("t4_vid_before_cpu", vid_before_cpu, 3);
        check("t4_cpu_acks", n_cpu, 1);
`else
        check("t4_cpu_acks", n_cpu, 0);
        check("t4_vid_acks", n_vid, 10);
        check("t4_wait_n", cpu_wait_n, 0);
`endif
        vid_req = 0; cpu_req = 0;
        do_reset();
        tick();

        // 5. Reset during WAIT of a video read, then a fresh CPU read
        vid_req = 1; vid_addr = 25'h00600; sd_dout = 8'h99;
        tick();
        check("t5_oe_c1", sd_oe, 1);
        tick();
        reset = 1;
        tick();
        check("t5_no_ack", vid_ack, 0);
        check("t5_oe_after_rst", sd_oe, 0);
        check("t5_vid_data", vid_data, 0);
        reset = 0; vid_req = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 25'h00700; sd_dout = 8'h42;
        tick();
        check("t5_cpu_issue", sd_oe, 1);
        check("t5_cpu_addr", sd_addr, 25'h00700);
        check("t5_vid_ack_late", vid_ack, 0);
        tick();
        tick();
        check("t5_cpu_ack", cpu_ack, 1);
        check("t5_cpu_dout", cpu_dout, 8'h42);
        cpu_req = 0;
        do_reset();
        tick();

        // 6. Video read on the RD_LAT=3 instance; sd_dout changes every cycle
        vid_req = 1; vid_addr = 25'h01234; sd_dout = 8'h00;
        tick();
        sd_dout = 8'h11;
        check("t6_oe3_c1", sd_oe3, 1);
        check("t6_addr3_c1", sd_addr3, 25'h01234);
        tick();
        sd_dout = 8'h22;
        check("t6_oe3_c2", sd_oe3, 0);
        tick();
        sd_dout = 8'h33;
        check("t6_ack3_c3", vid_ack3, 0);
        check("t6_ack1_c3", vid_ack, 1);
        check("t6_data1", vid_data, 8'h22);
        tick();
        sd_dout = 8'h44;
        check("t6_ack3_c4", vid_ack3, 0);
        tick();
        check("t6_ack3_c5", vid_ack3, 1);
        check("t6_data3", vid_data3, 8'h44);
        vid_req = 0;
        tick();
        check("t6_ack3_c6", vid_ack3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/laser500_mem_arbiter.md
Name: laser500_mem_arbiter

Overview:
Single-owner access scheduler for the shared SDRAM port. Arbitrates between three requesters:
- ROM/image download path (data_io), write-only.
- Video fetch (VTL chip), read-only.
- Z80 CPU, read/write, with WAIT_n generation.

It issues exactly one access slot at a time to the sdram controller's din/addr/we/oe interface and returns read data and acks to the winning requester. It sits between the requesters and the sdram instance in the Laser500 top level, on the F14M clock domain.

Parameters:
ADDR_W, 25, width of every address bus.
RD_LAT, 1, cycles from the issue cycle until sd_dout is valid. Legal range 1..7.
MAX_VID_STREAK, 3, consecutive video grants allowed while a CPU request waits. Used only with the optional feature.

Ports:
clk  in  1  F14M system clock
reset  in  1  synchronous, active-high reset
dio_req  in  1  download write request, level, held until dio_ack
dio_addr  in  ADDR_W  download address
dio_data  in  8  download write data
dio_ack  out  1  one-cycle completion pulse
vid_req  in  1  video read request, level, held until vid_ack
vid_addr  in  ADDR_W  video address
vid_data  out  8  video read data, registered
vid_ack  out  1  one-cycle completion pulse
cpu_req  in  1  CPU request, level, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  paged CPU address
cpu_din  in  8  CPU write data
cpu_dout  out  8  CPU read data, registered
cpu_ack  out  1  one-cycle completion pulse
cpu_wait_n  out  1  Z80 WAIT_n, low while a CPU access is pending
sd_addr  out  ADDR_W  to sdram addr
sd_din  out  8  to sdram din
sd_we  out  1  to sdram we
sd_oe  out  1  to sdram oe
sd_dout  in  8  from sdram dout

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- FSM states:
  - ARB: decide. If any unmasked request exists, latch grant, address, data and we into registers, then go to ISSUE. Otherwise stay in ARB.
  - ISSUE: exactly one cycle. Drive sd_oe=1 for a read or sd_we=1 for a write; sd_addr and sd_din come from the latched registers. Load lat_cnt=RD_LAT-1, then go to WAIT.
  - WAIT: decrement lat_cnt. When lat_cnt==0, capture sd_dout into the granted requester's data register on a read, set that requester's ack register, and go to ARB.
- Priority: dio > vid > cpu, fixed.
- Ack timing:
  - Ack is registered and high for exactly one cycle, the cycle after the final WAIT cycle, during which the FSM is in ARB.
  - In that ARB cycle the just-acked requester's req is masked, so a held req is treated as a new request one cycle later.
- Latency: req high in ARB at cycle 0 → ISSUE at 1 → ack at 2+RD_LAT. With RD_LAT=1 a continuously requesting master gets one access per 4 cycles.
- Bus values outside ISSUE:
  - sd_we and sd_oe are 0.
  - sd_addr and sd_din hold their last latched value.
- Data registers: vid_data and cpu_dout update only on that requester's read completion and hold otherwise. CPU writes do not alter cpu_dout.
- cpu_wait_n = !(cpu_req && !cpu_ack), combinational.
- Requests are never pre-empted. A higher-priority request arriving during ISSUE or WAIT waits for the next ARB.
- Dropping req before ack is a protocol violation. The granted access still completes and acks.
- Reset values:
  - State = ARB.
  - All acks, sd_we and sd_oe = 0.
  - sd_addr, sd_din, vid_data and cpu_dout = 0.
  - cpu_wait_n follows its equation.
  - Streak counter = 0.
- Reset mid-access: the next edge returns the FSM to ARB with no ack emitted and sd_we/sd_oe deasserted.

Optional Feature:
LASER500_CPU_FAIRNESS_EN
- Defined:
  - A 3-bit streak counter increments on each video grant made while cpu_req is high and unmasked.
  - When the counter equals MAX_VID_STREAK, the next ARB grants the CPU over video. dio still wins.
  - The counter clears on any CPU grant, and whenever cpu_req is low in ARB.
- Undefined: strict dio > vid > cpu priority; the counter logic is absent.

Test Plan:
1. Reset, then CPU read cpu_addr=0x04000, sd_dout=0x5A, RD_LAT=1 → sd_oe high only in cycle 1; cpu_ack in cycle 3; cpu_dout=0x5A; cpu_wait_n low in cycles 0–2, high in cycle 3.
2. CPU write 0xC3 to 0x08001 → sd_we=1 for one cycle with sd_addr=0x08001 and sd_din=0xC3; cpu_dout unchanged.
3. dio_req, vid_req and cpu_req all raised in the same cycle → grant order dio, vid, cpu; acks at cycles 3, 7, 11.
4. vid_req held high continuously plus cpu_req, feature undefined → CPU never acked over 40 cycles. Feature defined with MAX_VID_STREAK=3 → CPU acked after exactly 3 video acks.
5. Assert reset during WAIT of a video read → no vid_ack; sd_oe=0 the next cycle; vid_data=0; FSM accepts a fresh cpu_req 1 cycle after reset is released.
6. RD_LAT=3 video read → sd_dout sampled 3 cycles after ISSUE; vid_ack at cycle 5.
